tcp_state_rd_arb: RTL

- Two-requester arbiter that shares one flow-state memory read port between the RX pipeline (requester 0) and the TX pipeline (requester 1).
- Sits between both pipelines and the flow-state RAM wrapper, which accepts val/rdy read requests and returns responses in order.
- Grants one request per cycle and records the winner in an outstanding-tag FIFO.
- Routes each returning response to the requester that issued it.

---
 rtl/tcp_state_rd_arb_if.sv | 31 +++
 rtl/tcp_state_rd_arb.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/tcp_state_rd_arb_if.sv
`default_nettype none
// ============================================================================
//  Module      : tcp_state_rd_arb_if
//  Description : Read request/response channel for the flow-state memory.
//                Requests and responses each use a val/rdy handshake.
//                The master drives requests and consumes responses.
//                The slave accepts requests and returns responses.
//  Revision    : 1.0  initial release
// ============================================================================
interface tcp_state_rd_arb_if #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 128
);
    logic              req_val;
    logic [ADDR_W-1:0] req_addr;
    logic              req_rdy;
    logic              resp_val;
    logic [DATA_W-1:0] resp_data;
    logic              resp_rdy;

    modport master (
        output req_val, req_addr, resp_rdy,
        input  req_rdy, resp_val, resp_data
    );

    modport slave (
        input  req_val, req_addr, resp_rdy,
        output req_rdy, resp_val, resp_data
    );
endinterface
`default_nettype wire

// File: rtl/tcp_state_rd_arb.sv
`default_nettype none
// ============================================================================
//  Module      : tcp_state_rd_arb
//  Description : Shares one flow-state RAM read port between the RX
//                pipeline (requester 0) and the TX pipeline (requester 1).
//                Requests are arbitrated round-robin, and each grant is
//                tagged into an in-order FIFO. Each returning response is
//                routed to the requester that issued the matching read.
//                Optional macro STATE_RD_ARB_STRICT_PRIO_EN makes RX win
//                every tie instead of alternating.
//  Revision    : 1.0  initial release
// ============================================================================
module tcp_state_rd_arb #(
    parameter int ADDR_W          = 6,
    parameter int DATA_W          = 128,
    parameter int MAX_OUTSTANDING = 4
) (
    input  wire logic                               clk,
    input  wire logic                               rst,    // active-low, asynchronous
    tcp_state_rd_arb_if.slave                       rx,
    tcp_state_rd_arb_if.slave                       tx,
    tcp_state_rd_arb_if.master                      mem,
    output logic [$clog2(MAX_OUTSTANDING):0]        outstanding_cnt,
    output logic                                    unexp_resp_err
);
    localparam int c_idx_w = $clog2(MAX_OUTSTANDING);
    localparam int c_cnt_w = c_idx_w + 1;
    localparam logic [c_cnt_w-1:0] c_max_out = c_cnt_w'(MAX_OUTSTANDING);
    localparam logic [c_cnt_w-1:0] c_one     = c_cnt_w'(1);

    logic [c_cnt_w-1:0]         r_cnt;
    logic [c_cnt_w-1:0]         r_wr_ptr;
    logic [c_cnt_w-1:0]         r_rd_ptr;
    logic [MAX_OUTSTANDING-1:0] r_tag;
    logic                       r_last_grant;
    logic                       r_err;

    logic              w_any_val;
    logic              w_not_full;
    logic              w_can_issue;
    logic              w_winner;
    logic              w_issue;
    logic              w_empty;
    logic              w_head;
    logic              w_dest_rdy;
    logic              w_pop;
    logic [DATA_W-1:0] w_resp_data;

    assign w_any_val   = rx.req_val | tx.req_val;
    assign w_not_full  = (r_cnt < c_max_out);
    // A response leaving this cycle is deliberately not credited here.
    assign w_can_issue = w_not_full & mem.req_rdy;
    assign w_issue     = w_any_val & w_can_issue;

    // Pick the winner: a lone requester wins; ties alternate or favour RX.
    always_comb begin
        w_winner = 1'b0;
        if (rx.req_val && tx.req_val) begin
`ifdef STATE_RD_ARB_STRICT_PRIO_EN
            w_winner = 1'b0;
`else
            w_winner = ~r_last_grant;
`endif
        end else if (tx.req_val) begin
            w_winner = 1'b1;
        end
    end

    assign w_empty     = (r_wr_ptr == r_rd_ptr);
    assign w_head      = r_tag[r_rd_ptr[c_idx_w-1:0]];
    assign w_dest_rdy  = w_head ? tx.resp_rdy : rx.resp_rdy;
    assign w_pop       = mem.resp_val & ~w_empty & w_dest_rdy;
    assign w_resp_data = mem.resp_data;

    // Valid outputs are held low while reset is asserted.
    assign mem.req_val   = rst & w_any_val & w_not_full;
    assign mem.req_addr  = w_winner ? tx.req_addr : rx.req_addr;
    assign rx.req_rdy    = rst & w_issue & ~w_winner;
    assign tx.req_rdy    = rst & w_issue &  w_winner;

    assign mem.resp_rdy  = ~w_empty & w_dest_rdy;
    assign rx.resp_val   = rst & mem.resp_val & ~w_empty & ~w_head;
    assign tx.resp_val   = rst & mem.resp_val & ~w_empty &  w_head;
    assign rx.resp_data  = w_resp_data;
    assign tx.resp_data  = w_resp_data;

    assign outstanding_cnt = r_cnt;
    assign unexp_resp_err  = r_err;

    // Record the owner of each issued read in arrival order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_tag <= '0;
        end else if (w_issue) begin
            r_tag[r_wr_ptr[c_idx_w-1:0]] <= w_winner;
        end
    end

    // Advance the tag FIFO pointers on push and pop; they wrap naturally.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_issue) begin
                r_wr_ptr <= r_wr_ptr + c_one;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_one;
            end
        end
    end

    // Track reads in flight; a push and a pop in one cycle cancel out.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= '0;
        end else begin
            case ({w_issue, w_pop})
                2'b10:   r_cnt <= r_cnt + c_one;
                2'b01:   r_cnt <= r_cnt - c_one;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    // Remember the last grant so that the other side wins the next tie.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_last_grant <= 1'b1;
        end else if (w_issue) begin
            r_last_grant <= w_winner;
        end
    end

    // Flag a response that has no matching outstanding read; stays set until reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_err <= 1'b0;
        end else if (mem.resp_val && w_empty) begin
            r_err <= 1'b1;
        end
    end
endmodule
`default_nettype wire
